alu_rr_scheduler: RTL

//  Shares the single 4-bit ALU between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_rr_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU scheduler: data/opcode widths and FSM states.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int OP_W  = 2;
  localparam int CNT_W = 8;

  typedef logic [ALU_W-1:0] alu_data_t;
  typedef logic [OP_W-1:0]  alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational masked-priority round-robin arbiter: the search starts just above
// ptr_i and wraps to bit 0, producing a one-hot grant (all-zero when no request).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] hi_s;
  logic [N-1:0] grant_hi_s;
  logic [N-1:0] grant_all_s;

  // Lowest-index pick among requests above the pointer, falling back to a plain pick.
  always_comb begin : pick
    logic seen_hi;
    logic seen_all;
    seen_hi     = 1'b0;
    seen_all    = 1'b0;
    hi_s        = '0;
    grant_hi_s  = '0;
    grant_all_s = '0;
    for (int i = 0; i < N; i++) begin
      hi_s[i]        = req_i[i] & (PW'(i) > ptr_i);
      grant_hi_s[i]  = hi_s[i] & ~seen_hi;
      seen_hi        = seen_hi | hi_s[i];
      grant_all_s[i] = req_i[i] & ~seen_all;
      seen_all       = seen_all | req_i[i];
    end
    grant_o = seen_hi ? grant_hi_s : grant_all_s;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one 4-bit ALU between NUM_REQ requesters: round-robin grant, single
// outstanding op, done-timeout abort, one-cycle response pulse to the owner.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [4*NUM_REQ-1:0]   req_a_i,
  input  logic [4*NUM_REQ-1:0]   req_b_i,
  input  logic [2*NUM_REQ-1:0]   req_op_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [3:0]             rsp_result_o,
  output logic                   rsp_err_o,
  output logic [3:0]             alu_a_o,
  output logic [3:0]             alu_b_o,
  output logic [1:0]             alu_op_o,
  output logic                   alu_start_o,
  input  logic [3:0]             alu_result_i,
  input  logic                   alu_done_i,
  output logic                   busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_e       state_q;
  sched_state_e       state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] owner_oh_q;
  logic [CNT_W-1:0]   cnt_q;
  alu_data_t          alu_a_q;
  alu_data_t          alu_b_q;
  alu_op_t            alu_op_q;
  logic               alu_start_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  alu_data_t          rsp_result_q;
  logic               rsp_err_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   grant_idx_s;
  alu_data_t          sel_a_s;
  alu_data_t          sel_b_s;
  alu_op_t            sel_op_s;
  logic               accept_s;
  logic               timeout_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant_s)
  );

  assign req_ready_o = grant_s & {NUM_REQ{(state_q == S_IDLE) && resetn_i}};
  assign accept_s    = |req_ready_o;
  assign timeout_s   = (cnt_q == TMO_LAST);

  // One-hot grant to owner index and operand select.
  always_comb begin
    grant_idx_s = '0;
    sel_a_s     = '0;
    sel_b_s     = '0;
    sel_op_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_idx_s = grant_idx_s | (grant_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      sel_a_s     = sel_a_s  | (req_a_i[4*i +: 4]  & {4{grant_s[i]}});
      sel_b_s     = sel_b_s  | (req_b_i[4*i +: 4]  & {4{grant_s[i]}});
      sel_op_s    = sel_op_s | (req_op_i[2*i +: 2] & {2{grant_s[i]}});
    end
  end

  // Next-state logic: done has priority over a coincident timeout in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (alu_done_i || timeout_s) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand/owner capture, timeout counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= PTR_RST;
      owner_q      <= '0;
      owner_oh_q   <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      alu_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            alu_a_q     <= sel_a_s;
            alu_b_q     <= sel_b_s;
            alu_op_q    <= sel_op_s;
            owner_q     <= grant_idx_s;
            owner_oh_q  <= grant_s;
            alu_start_q <= 1'b1;
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (alu_done_i) begin
            rsp_result_q <= alu_result_i;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= owner_oh_q;
          end else if (timeout_s) begin
            rsp_result_q <= 4'd0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= owner_oh_q;
          end
        end
        S_RESP:  ptr_q <= owner_q;
        default: ptr_q <= ptr_q;
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_err_o    = rsp_err_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign alu_start_o  = alu_start_q;
  assign busy_o       = busy_q;

endmodule
